imm_ext_ctrl: RTL and testbench
===============================

Name: imm_ext_ctrl

Overview:
Sequencer for the 16-bit immediate-extension datapath in the decode stage. It takes 8-bit immediates from decode together with an extension mode, and produces a registered 16-bit operand for the execute stage. It supports a PREFIX mode that holds a high byte and merges it with the next immediate to form a full 16-bit constant. The two stages are linked by a valid/ready handshake with one output register.

Parameters:
IMM_W, 8, width of the raw immediate field
OUT_W, 16, width of the extended operand; must equal 2*IMM_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous pipeline flush; drops held prefix and output
in_valid  input  1  decode presents an immediate
in_ready  output  1  block accepts this cycle
imm  input  IMM_W  raw immediate field
mode  input  2  00 ZERO, 01 SIGN, 10 UPPER, 11 PREFIX
out_valid  output  1  ext_imm holds a valid operand
out_ready  input  1  execute consumes the operand
ext_imm  output  OUT_W  extended operand
ext_merged  output  1  current ext_imm was built from a prefix
prefix_err  output  1  sticky flag: a PREFIX followed a PREFIX

Behaviour:
- Reset: rst=1 asynchronously clears the state to IDLE and clears all outputs: out_valid=0, ext_imm=0, ext_merged=0, prefix_err=0, hi_reg=0.
- in_ready is combinational: in_ready = !out_valid || out_ready. It is independent of in_valid and of the state, so a PREFIX can be accepted while the output is full and draining.
- Accept = in_valid && in_ready.
- Extension rules for an accepted non-PREFIX beat with no held prefix:
  - ZERO: {8'h00, imm}
  - SIGN: {{8{imm[7]}}, imm}
  - UPPER: {imm, 8'h00}
- Held prefix:
  - Accepted PREFIX: imm is latched into hi_reg, the state becomes HELD, and no output beat is produced.
  - Next accepted non-PREFIX beat while HELD: ext_imm = {hi_reg, imm} regardless of mode, ext_merged=1, and the state returns to IDLE.
  - Accepted PREFIX while HELD: hi_reg is overwritten, prefix_err is set, and the state stays HELD.
- States:
  - IDLE -> HELD on an accepted PREFIX.
  - HELD -> IDLE on an accepted non-PREFIX beat.
  - flush forces the state to IDLE from any state.
- Output register and latency:
  - Latency is 1 cycle: an operand accepted at edge N is visible with out_valid=1 after edge N.
  - out_valid clears on out_ready && out_valid unless a new beat is accepted in the same cycle.
  - Simultaneous consume and accept replaces the register, so back-to-back throughput is 1 beat per cycle.
  - While out_valid=1 && out_ready=0, ext_imm and ext_merged hold stable.
- flush (synchronous, takes priority over everything except rst):
  - Next edge: out_valid=0, state=IDLE, hi_reg=0.
  - Any beat presented in the same cycle is discarded.
  - prefix_err is not cleared by flush; only rst clears it.
- ext_merged is updated only when a beat loads into the output register.
- Reset mid-operation: a held prefix and any pending output are lost, and out_valid drops immediately.

Test Plan:
- Reset, then ZERO imm=8'b00001011 with out_ready=1 -> one cycle later out_valid=1, ext_imm=16'h000B, ext_merged=0.
- SIGN imm=8'b10010100 -> ext_imm=16'hFF94; ZERO imm=8'hFF -> 16'h00FF; UPPER imm=8'h12 -> 16'h1200.
- Send PREFIX imm=8'hAB, then SIGN imm=8'hCD:
  - No output after the PREFIX.
  - After the second beat, ext_imm=16'hABCD and ext_merged=1.
- Backpressure: with out_ready=0 and an output held, send ZERO 8'h01 -> in_ready=0 and ext_imm stays stable. Raise out_ready -> next beat loads, with no loss and no duplication.
- Double prefix:
  - Send PREFIX 8'h11, PREFIX 8'h22, ZERO 8'h33 -> ext_imm=16'h2233 and prefix_err=1.
  - prefix_err stays 1 through a flush and clears only on rst.
- Flush while HELD after PREFIX 8'h55, then ZERO 8'h66 -> ext_imm=16'h0066 and ext_merged=0. Assert rst asynchronously mid-cycle -> out_valid drops immediately.

Source files
------------

// File: rtl/imm_ext_ctrl.sv
// imm_ext_ctrl: decode-stage immediate-extension sequencer.
// Takes IMM_W-bit immediates with an extension mode and produces a registered OUT_W-bit
// operand for execute. A PREFIX beat holds a high byte that is merged with the next
// immediate to form a full constant.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   flush         synchronous flush: drops held prefix and pending output
//   in_valid      decode presents an immediate
//   in_ready      block accepts this cycle (!out_valid || out_ready)
//   imm, mode     raw immediate; mode 00 ZERO, 01 SIGN, 10 UPPER, 11 PREFIX
//   out_valid     ext_imm holds a valid operand
//   out_ready     execute consumes the operand
//   ext_imm       extended operand
//   ext_merged    ext_imm was built from a held prefix
//   prefix_err    sticky: a PREFIX followed a PREFIX (cleared only by rst)
module imm_ext_ctrl #(
  parameter int unsigned IMM_W = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext_imm,
  output logic             ext_merged,
  output logic             prefix_err
);

  typedef enum logic [0:0] {StIdle, StHeld} state_e;

  localparam logic [1:0] ModeZero   = 2'b00;
  localparam logic [1:0] ModeSign   = 2'b01;
  localparam logic [1:0] ModeUpper  = 2'b10;
  localparam logic [1:0] ModePrefix = 2'b11;

  state_e             state_q, state_d;
  logic [IMM_W-1:0]   hi_q, hi_d;
  logic               valid_q, valid_d;
  logic [OUT_W-1:0]   ext_q, ext_d;
  logic               merged_q, merged_d;
  logic               err_q, err_d;

  logic               accept;
  logic               is_prefix;
  logic [OUT_W-1:0]   ext_plain;

  // Ready depends only on the output register so a PREFIX can be taken while draining.
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_prefix = (mode == ModePrefix);

  always_comb begin
    ext_plain = '0;
    unique case (mode)
      ModeZero:  ext_plain = {{IMM_W{1'b0}}, imm};
      ModeSign:  ext_plain = {{IMM_W{imm[IMM_W-1]}}, imm};
      ModeUpper: ext_plain = {imm, {IMM_W{1'b0}}};
      default:   ext_plain = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    valid_d  = valid_q;
    ext_d    = ext_q;
    merged_d = merged_q;
    err_d    = err_q;

    if (flush) begin
      // Flush discards any beat presented this cycle; prefix_err survives.
      state_d = StIdle;
      hi_d    = '0;
      valid_d = 1'b0;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      if (accept && is_prefix) begin
        hi_d    = imm;
        state_d = StHeld;
        if (state_q == StHeld) begin
          err_d = 1'b1;
        end
      end else if (accept) begin
        // A held prefix overrides the mode for the merged beat.
        if (state_q == StHeld) begin
          ext_d    = {hi_q, imm};
          merged_d = 1'b1;
        end else begin
          ext_d    = ext_plain;
          merged_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      valid_q  <= 1'b0;
      ext_q    <= '0;
      merged_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      valid_q  <= valid_d;
      ext_q    <= ext_d;
      merged_q <= merged_d;
      err_q    <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign ext_imm    = ext_q;
  assign ext_merged = merged_q;
  assign prefix_err = err_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
module tb_imm_ext_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  imm;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ext_imm;
  logic        ext_merged;
  logic        prefix_err;

  int n_total;
  int n_pass;

  imm_ext_ctrl #(
    .IMM_W(8),
    .OUT_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ext_imm   (ext_imm),
    .ext_merged(ext_merged),
    .prefix_err(prefix_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  imm;
    logic        exp_valid;
    logic [15:0] exp_ext;
    logic        exp_merged;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    imm       = 8'h00;
    mode      = 2'b00;
    out_ready = 1'b1;

    // mode: 00 ZERO, 01 SIGN, 10 UPPER, 11 PREFIX
    vecs[0] = '{2'b00, 8'b00001011, 1'b1, 16'h000B, 1'b0};
    vecs[1] = '{2'b01, 8'b10010100, 1'b1, 16'hFF94, 1'b0};
    vecs[2] = '{2'b00, 8'hFF,       1'b1, 16'h00FF, 1'b0};
    vecs[3] = '{2'b10, 8'h12,       1'b1, 16'h1200, 1'b0};
    vecs[4] = '{2'b01, 8'h7F,       1'b1, 16'h007F, 1'b0};
    vecs[5] = '{2'b11, 8'hAB,       1'b0, 16'h0000, 1'b0};
    vecs[6] = '{2'b01, 8'hCD,       1'b1, 16'hABCD, 1'b1};
    vecs[7] = '{2'b10, 8'h34,       1'b1, 16'h3400, 1'b0};
    vecs[8] = '{2'b11, 8'h12,       1'b0, 16'h0000, 1'b0};
    vecs[9] = '{2'b10, 8'h56,       1'b1, 16'h1256, 1'b1};

    step();
    step();
    check("reset out_valid",  16'(out_valid),  16'h0);
    check("reset ext_imm",    ext_imm,         16'h0000);
    check("reset ext_merged", 16'(ext_merged), 16'h0);
    check("reset prefix_err", 16'(prefix_err), 16'h0);
    rst = 1'b0;
    #1;
    check("reset in_ready",   16'(in_ready),   16'h1);

    // Streaming table with out_ready held high: one beat per cycle.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      mode     = vecs[i].mode;
      imm      = vecs[i].imm;
      #1;
      check($sformatf("vec%0d in_ready", i), 16'(in_ready), 16'h1);
      step();
      check($sformatf("vec%0d out_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d ext_imm", i), ext_imm, vecs[i].exp_ext);
        check($sformatf("vec%0d ext_merged", i), 16'(ext_merged), 16'(vecs[i].exp_merged));
      end
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", 16'(out_valid), 16'h0);

    // Backpressure: load 0x0001, then stall a second beat.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'b00;
    imm       = 8'h01;
    step();
    check("bp first valid", 16'(out_valid), 16'h1);
    check("bp first ext",   ext_imm,        16'h0001);
    imm = 8'h02;
    #1;
    check("bp in_ready low", 16'(in_ready), 16'h0);
    step();
    check("bp hold valid", 16'(out_valid), 16'h1);
    check("bp hold ext",   ext_imm,        16'h0001);
    step();
    check("bp hold2 ext",  ext_imm,        16'h0001);
    out_ready = 1'b1;
    #1;
    check("bp in_ready high", 16'(in_ready), 16'h1);
    step();
    check("bp second valid", 16'(out_valid), 16'h1);
    check("bp second ext",   ext_imm,        16'h0002);
    in_valid = 1'b0;
    step();
    check("bp no dup", 16'(out_valid), 16'h0);

    // Double prefix sets the sticky error; last prefix wins.
    in_valid = 1'b1;
    mode     = 2'b11;
    imm      = 8'h11;
    step();
    check("dp no output", 16'(out_valid), 16'h0);
    check("dp err clear", 16'(prefix_err), 16'h0);
    imm = 8'h22;
    step();
    check("dp err set", 16'(prefix_err), 16'h1);
    mode = 2'b00;
    imm  = 8'h33;
    step();
    check("dp ext",    ext_imm,         16'h2233);
    check("dp merged", 16'(ext_merged), 16'h1);
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    check("dp flush valid", 16'(out_valid),  16'h0);
    check("dp err sticky",  16'(prefix_err), 16'h1);

    // Flush discards a beat presented in the same cycle.
    flush    = 1'b1;
    in_valid = 1'b1;
    mode     = 2'b00;
    imm      = 8'h77;
    step();
    check("flush discards beat", 16'(out_valid), 16'h0);
    flush = 1'b0;

    // Flush while HELD drops the prefix.
    mode = 2'b11;
    imm  = 8'h55;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    mode      = 2'b00;
    imm       = 8'h66;
    step();
    in_valid = 1'b0;
    check("fh valid",  16'(out_valid),  16'h1);
    check("fh ext",    ext_imm,         16'h0066);
    check("fh merged", 16'(ext_merged), 16'h0);

    // Asynchronous reset mid-cycle drops the output immediately.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst valid", 16'(out_valid),  16'h0);
    check("async rst ext",   ext_imm,         16'h0000);
    check("async rst err",   16'(prefix_err), 16'h0);
    step();
    rst = 1'b0;
    step();
    check("post rst valid", 16'(out_valid), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
